// File: rtl/ncl_mult3_sync_bridge.sv
// Synchronous bridge between a valid/ready binary interface and a 3x3 dual-rail NCL
// multiplier: it encodes operands to rails, runs the DATA/NULL handshake and buffers one product.
`timescale 1ns/1ps
module ncl_mult3_sync_bridge #(
    parameter int TIMEOUT     = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [2:0] in_a,
    input  logic [2:0] in_b,
    output logic       in_ready,
    output logic [2:0] a_rail1,
    output logic [2:0] a_rail0,
    output logic [2:0] b_rail1,
    output logic [2:0] b_rail0,
    output logic       ki_o,
    input  logic       ko_i,
    input  logic [5:0] p_rail1,
    input  logic [5:0] p_rail0,
    output logic       out_valid,
    output logic [5:0] out_p,
    input  logic       out_ready,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_RAIL    = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        NULLW = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [SYNC_N-1:0]  ko_sync;
    logic               ko_s;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_hit;
    logic               cnt_inc;
    logic               capture;
    logic               buf_free;
    logic               drain;
    logic               rail_bad;
    logic               set_err;
    logic [1:0]         err_code_nxt;

    // The completion signal from the multiplier is asynchronous; only ko_s is used below.
    always_ff @(posedge clk) begin
        if (rst) begin
            ko_sync <= '0;
        end else begin
            ko_sync <= {ko_sync[SYNC_N-2:0], ko_i};
        end
    end

    assign ko_s     = ko_sync[SYNC_N-1];
    assign drain    = out_valid & out_ready;
    assign buf_free = ~out_valid | out_ready;
    assign rail_bad = |(~(p_rail1 ^ p_rail0));
    assign cnt_hit  = (cnt == CNT_W'(TIMEOUT - 1));

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        in_ready     = 1'b0;
        capture      = 1'b0;
        cnt_inc      = 1'b0;
        set_err      = 1'b0;
        err_code_nxt = ERR_NONE;
        unique case (state)
            IDLE: begin
                in_ready = ko_s;
                if (in_valid && ko_s) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (!ko_s) begin
                    // Product complete; a full, undrained buffer stalls with the counter frozen.
                    if (buf_free) begin
                        capture = 1'b1;
                        if (rail_bad) begin
                            state_nxt    = ERR;
                            set_err      = 1'b1;
                            err_code_nxt = ERR_RAIL;
                        end else begin
                            state_nxt = NULLW;
                        end
                    end
                end else if (cnt_hit) begin
                    state_nxt    = ERR;
                    set_err      = 1'b1;
                    err_code_nxt = ERR_TIMEOUT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            NULLW: begin
                if (ko_s) begin
                    state_nxt = IDLE;
                end else if (cnt_hit) begin
                    state_nxt    = ERR;
                    set_err      = 1'b1;
                    err_code_nxt = ERR_TIMEOUT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ERR: begin
                state_nxt = ERR;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments; reset is synchronous, so rst is a data input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ki_o     <= 1'b1;
            a_rail1  <= '0;
            a_rail0  <= '0;
            b_rail1  <= '0;
            b_rail0  <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            state <= state_nxt;

            if (state_nxt != state) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (set_err && !err) begin
                err      <= 1'b1;
                err_code <= err_code_nxt;
            end

            // Rails carry the operands only while in DATA; they double as the operand register.
            if (state_nxt == DATA) begin
                if (state == IDLE) begin
                    a_rail1 <= in_a;
                    a_rail0 <= ~in_a;
                    b_rail1 <= in_b;
                    b_rail0 <= ~in_b;
                end
            end else begin
                a_rail1 <= '0;
                a_rail0 <= '0;
                b_rail1 <= '0;
                b_rail0 <= '0;
            end

            ki_o <= (state_nxt == IDLE) || (state_nxt == DATA);
        end
    end

    // One-entry output buffer; a capture on the draining edge replaces the held product.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_p     <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_p     <= p_rail1;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/ncl_mult3_sync_bridge.md
NCL_MULT3_SYNC_BRIDGE -- requirements
Module: ncl_mult3_sync_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: max clk cycles allowed in any wait state before error.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flop depth of the ko_i synchronizer, minimum 2.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_a, in_b  input  3 each  unsigned binary operands.
REQ-007 in_ready  output  1  operand pair accepted when in_valid&in_ready at a clk edge.
REQ-008 a_rail1, a_rail0, b_rail1, b_rail0  output  3 each  dual-rail operands to the multiplier, driven from flops.
REQ-009 ki_o  output  1  request to the multiplier: 1 = request DATA, 0 = request NULL.
REQ-010 ko_i  input  1  multiplier acknowledge, asynchronous: 1 = all outputs NULL, 0 = all outputs DATA.
REQ-011 p_rail1, p_rail0  input  6 each  dual-rail product from the multiplier, asynchronous.
REQ-012 out_valid  output  1  product held in out_p.
REQ-013 out_p  output  6  binary product.
REQ-014 out_ready  input  1  consumer takes out_p when out_valid&out_ready.
REQ-015 err  output  1  sticky error flag.
REQ-016 err_code  output  2  error cause: 0 none, 1 timeout, 2 illegal rail pair; first cause wins.

Function
REQ-017 SHALL pass ko_i through SYNC_STAGES flops; ko_s is the last stage; no other block logic reads ko_i directly.
REQ-018 SHALL implement FSM states IDLE, DATA, NULLW, ERR.
REQ-019 IDLE: rails all 0 (NULL), ki_o=1, in_ready=ko_s; on accept, register operands and go to DATA next cycle.
REQ-020 DATA: a_rail1=in_a, a_rail0=~in_a, same for b; ki_o=1; in_ready=0.
REQ-021 DATA exit: when ko_s==0 and output buffer is empty or being drained that cycle, sample p rails into out_p (out_p[i]=p_rail1[i]), set out_valid, go to NULLW.
REQ-022 DATA with ko_s==0 and buffer full and not draining: stay in DATA with rails and ki_o held, and the timeout counter frozen.
REQ-023 On the DATA capture edge, any bit with p_rail1[i]==p_rail0[i] SHALL set err, with err_code=2, and the next state is ERR.
REQ-024 NULLW: rails all 0, ki_o=0; when ko_s==1, go to IDLE and set ki_o=1.
REQ-025 Minimum cycle per operation is 1 accept + sync latency + 1 capture + sync latency; back-to-back accepts are allowed once IDLE is re-entered with ko_s==1.
REQ-026 The output buffer is one entry; out_valid clears on out_valid&out_ready unless a capture occurs on the same edge, in which case it stays 1 and out_p takes the new value.
REQ-027 out_p and out_valid SHALL be independent of FSM state except capture; draining is allowed in any state, including ERR.
REQ-028 The timeout counter SHALL clear on every state change and increment each cycle in DATA (except when frozen per REQ-022) and in NULLW.
REQ-029 When the counter reaches TIMEOUT, SHALL set err with err_code=1 and go to ERR.
REQ-030 ERR: rails all 0, ki_o=0, in_ready=0; remain until rst.
REQ-031 Operand width: 3x3 unsigned; no product overflow (max 49 fits in 6 bits).

Reset
REQ-032 On rst at a clk edge: FSM=IDLE, all rail outputs 0, ki_o=1, in_ready=0 until ko_s==1, out_valid=0, out_p=0, err=0, err_code=0, counter=0, sync flops=0.
REQ-033 rst mid-operation SHALL abandon the transaction and drop the buffered result.
REQ-034 After rst, the first accept SHALL wait for ko_s==1, which guarantees the multiplier is NULL.

Verification
REQ-035 Send a=7, b=7 with an ideal NCL multiplier model -> out_p=49, out_valid=1, then ki_o=0, then return to IDLE.
REQ-036 Send the stream (5,3),(0,6),(4,2) with out_ready=1 -> outputs 15, 0, 8 in order; no err.
REQ-037 Send a=3, b=2 with out_ready=0 for 20 cycles -> out_p=6 held; second op (2,2) stalls in DATA with rails held; release out_ready -> outputs 6 then 4.
REQ-038 Model holds ko_i=1 after DATA -> err=1, err_code=1 after 64 cycles in DATA; state ERR; in_ready=0.
REQ-039 Model returns p_rail1[2]=p_rail0[2]=1 -> err=1, err_code=2, out_valid set, ERR entered.
REQ-040 Assert rst while in NULLW with out_valid=1 -> next cycle out_valid=0, rails 0, ki_o=1; the next op (1,1) yields 1.
